dcache_store_buffer: RTL and testbench



---
 rtl/dcache_store_buffer_if.sv | 56 +++++
 rtl/dcache_store_buffer.sv | 136 +++++++++++++
 tb/tb_dcache_store_buffer.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_store_buffer_if.sv
// Bus-command package and interface for the data-cache write-through store buffer.
// The master side is the controller plus main memory. The slave side is the store buffer.
`ifndef DATA_SIZE
`define DATA_SIZE 64
`endif
`ifndef NUM_MEM_TAGS
`define NUM_MEM_TAGS 15
`endif

package dcache_sb_pkg;
  localparam int DW = `DATA_SIZE;
  localparam int TW = $clog2(`NUM_MEM_TAGS);

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } bus_command_t;
endpackage

interface dcache_store_buffer_if;
  import dcache_sb_pkg::*;

  bus_command_t    dc2sb_command;
  logic [31:0]     dc2sb_addr;
  logic [DW-1:0]   dc2sb_data;
  logic [TW-1:0]   mem2proc_response;
  logic [DW-1:0]   mem2proc_data;
  logic [TW-1:0]   mem2proc_tag;

  bus_command_t    proc2mem_command;
  logic [31:0]     proc2mem_addr;
  logic [DW-1:0]   proc2mem_data;
  logic [TW-1:0]   sb2dc_response;
  logic [DW-1:0]   sb2dc_data;
  logic [TW-1:0]   sb2dc_tag;
  logic            sb_full;
  logic            sb_empty;
  logic            sb_ld_stall;

  modport master (
    output dc2sb_command, dc2sb_addr, dc2sb_data,
    output mem2proc_response, mem2proc_data, mem2proc_tag,
    input  proc2mem_command, proc2mem_addr, proc2mem_data,
    input  sb2dc_response, sb2dc_data, sb2dc_tag,
    input  sb_full, sb_empty, sb_ld_stall
  );

  modport slave (
    input  dc2sb_command, dc2sb_addr, dc2sb_data,
    input  mem2proc_response, mem2proc_data, mem2proc_tag,
    output proc2mem_command, proc2mem_addr, proc2mem_data,
    output sb2dc_response, sb2dc_data, sb2dc_tag,
    output sb_full, sb_empty, sb_ld_stall
  );
endinterface

// File: rtl/dcache_store_buffer.sv
// Write-through store buffer between the data-cache controller and main memory.
// Stores are queued (or coalesced per line). Loads bypass with priority unless
// their line is still buffered. Buffered lines drain whenever the bus is idle.
module dcache_store_buffer #(
  parameter int SB_DEPTH = 4
) (
  input logic             clock,
  input logic             reset,
  dcache_store_buffer_if.slave sb
);
  import dcache_sb_pkg::*;

  localparam int PW = $clog2(SB_DEPTH);
  localparam int CW = $clog2(SB_DEPTH + 1);

  logic [SB_DEPTH-1:0] ent_valid;
  logic [28:0]         ent_line [SB_DEPTH];
  logic [DW-1:0]       ent_data [SB_DEPTH];
  logic [PW-1:0]       head;
  logic [PW-1:0]       tail;
  logic [CW-1:0]       count;

  logic          any_match;
  logic [PW-1:0] match_idx;
  logic          is_store;
  logic          is_load;
  logic          full;
  logic          empty;
  logic          drain;
  logic          pop;
  logic          enq;
  logic          coal;
  logic          drop;
  logic          stall;

  bus_command_t  mem_cmd;
  logic [31:0]   mem_addr;
  logic [DW-1:0] mem_data;
  logic [TW-1:0] dc_resp;

  assign is_store = (sb.dc2sb_command == BUS_STORE);
  assign is_load  = (sb.dc2sb_command == BUS_LOAD);
  assign full     = (count == CW'(SB_DEPTH));
  assign empty    = (count == '0);

  // Line match of the request address against registered valid entries.
  // Coalescing keeps lines unique, so at most one entry can hit.
  always_comb begin
    any_match = 1'b0;
    match_idx = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (ent_valid[i] && (ent_line[i] == sb.dc2sb_addr[31:3])) begin
        any_match = 1'b1;
        match_idx = PW'(i);
      end
    end
  end

  // Per-cycle mode decode and memory-side command steering.
  always_comb begin
    enq      = 1'b0;
    coal     = 1'b0;
    drop     = 1'b0;
    stall    = 1'b0;
    drain    = 1'b0;
    pop      = 1'b0;
    mem_cmd  = BUS_NONE;
    mem_addr = '0;
    mem_data = '0;
    dc_resp  = '0;
    if (is_store) begin
      coal = any_match;
      enq  = !any_match && !full;
      drop = !any_match && full;
    end else if (is_load && !any_match) begin
      mem_cmd  = BUS_LOAD;
      mem_addr = sb.dc2sb_addr;
      dc_resp  = sb.mem2proc_response;
    end else begin
      // Idle bus, or a load held back behind its own buffered line.
      stall = is_load;
      drain = !empty;
    end
    if (drain) begin
      mem_cmd  = BUS_STORE;
      mem_addr = {ent_line[head], 3'b000};
      mem_data = ent_data[head];
      pop      = (sb.mem2proc_response != '0);
    end
  end

  // Control state: entry valid bits, pointers and occupancy.
  always_ff @(posedge clock) begin
    if (reset) begin
      ent_valid <= '0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
    end else begin
      if (enq) begin
        ent_valid[tail] <= 1'b1;
        tail            <= tail + PW'(1);
        count           <= count + CW'(1);
      end
      if (pop) begin
        ent_valid[head] <= 1'b0;
        head            <= head + PW'(1);
        count           <= count - CW'(1);
      end
    end
  end

  // Entry payload: written on enqueue, overwritten in place on coalesce.
  always_ff @(posedge clock) begin
    if (enq) begin
      ent_line[tail] <= sb.dc2sb_addr[31:3];
      ent_data[tail] <= sb.dc2sb_data;
    end else if (coal) begin
      ent_data[match_idx] <= sb.dc2sb_data;
    end
  end

  assign sb.proc2mem_command = mem_cmd;
  assign sb.proc2mem_addr    = mem_addr;
  assign sb.proc2mem_data    = mem_data;
  assign sb.sb2dc_response   = dc_resp;
  assign sb.sb2dc_data       = sb.mem2proc_data;
  assign sb.sb2dc_tag        = sb.mem2proc_tag;
  assign sb.sb_full          = full;
  assign sb.sb_empty         = empty;
  assign sb.sb_ld_stall      = stall;

  // A new line arriving while every entry is occupied would be lost.
  a_no_overflow: assert property (@(posedge clock) disable iff (reset) !drop);

endmodule

// File: tb/tb_dcache_store_buffer.sv
// Self-checking bench for dcache_store_buffer: directed scenarios followed by a
// randomized phase, all compared against a queue-based reference of the buffer.
`ifndef DATA_SIZE
`define DATA_SIZE 64
`endif
`ifndef NUM_MEM_TAGS
`define NUM_MEM_TAGS 15
`endif

module tb_dcache_store_buffer;
  import dcache_sb_pkg::*;

  localparam int SB_DEPTH = 4;

  typedef struct packed {
    logic [28:0]   line;
    logic [DW-1:0] data;
  } ent_t;

  logic clock;
  logic reset;
  dcache_store_buffer_if sbi ();

  dcache_store_buffer #(.SB_DEPTH(SB_DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .sb    (sbi.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  ent_t q[$];

  bus_command_t  obs_cmd;
  logic [31:0]   obs_addr;
  logic [DW-1:0] obs_data;
  logic [TW-1:0] obs_resp;
  logic          obs_stall;
  logic          obs_full;
  logic          obs_empty;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One bus cycle: drive inputs, compare outputs to the reference, then
  // advance the reference to the state the DUT holds after the next edge.
  task automatic step(input bus_command_t cmd, input logic [31:0] addr,
                      input logic [DW-1:0] data, input logic [TW-1:0] resp);
    int            mi;
    bit            do_drain;
    bit            do_pop;
    bus_command_t  e_cmd;
    logic [31:0]   e_addr;
    logic [DW-1:0] e_data;
    logic [TW-1:0] e_resp;
    logic          e_stall;
    logic [DW-1:0] md;
    logic [TW-1:0] mt;
    @(negedge clock);
    md = {$urandom, $urandom};
    mt = TW'($urandom_range(0, 15));
    sbi.dc2sb_command     = cmd;
    sbi.dc2sb_addr        = addr;
    sbi.dc2sb_data        = data;
    sbi.mem2proc_response = resp;
    sbi.mem2proc_data     = md;
    sbi.mem2proc_tag      = mt;
    #1;
    mi = -1;
    foreach (q[i]) if (q[i].line == addr[31:3]) mi = i;
    do_drain = 1'b0;
    do_pop   = 1'b0;
    e_cmd    = BUS_NONE;
    e_addr   = '0;
    e_data   = '0;
    e_resp   = '0;
    e_stall  = 1'b0;
    if (cmd == BUS_LOAD && mi < 0) begin
      e_cmd  = BUS_LOAD;
      e_addr = addr;
      e_resp = resp;
    end else if (cmd != BUS_STORE) begin
      e_stall  = (cmd == BUS_LOAD);
      do_drain = (q.size() > 0);
    end
    if (do_drain) begin
      e_cmd  = BUS_STORE;
      e_addr = {q[0].line, 3'b000};
      e_data = q[0].data;
      do_pop = (resp != '0);
    end
    obs_cmd   = sbi.proc2mem_command;
    obs_addr  = sbi.proc2mem_addr;
    obs_data  = sbi.proc2mem_data;
    obs_resp  = sbi.sb2dc_response;
    obs_stall = sbi.sb_ld_stall;
    obs_full  = sbi.sb_full;
    obs_empty = sbi.sb_empty;
    chk("cmd",      64'(obs_cmd),        64'(e_cmd));
    chk("addr",     64'(obs_addr),       64'(e_addr));
    chk("data",     obs_data,            e_data);
    chk("resp",     64'(obs_resp),       64'(e_resp));
    chk("stall",    64'(obs_stall),      64'(e_stall));
    chk("full",     64'(obs_full),       64'(q.size() == SB_DEPTH));
    chk("empty",    64'(obs_empty),      64'(q.size() == 0));
    chk("pt_data",  sbi.sb2dc_data,      md);
    chk("pt_tag",   64'(sbi.sb2dc_tag),  64'(mt));
    if (cmd == BUS_STORE) begin
      if (mi >= 0) q[mi].data = data;
      else if (q.size() < SB_DEPTH) q.push_back('{line: addr[31:3], data: data});
    end
    if (do_pop) void'(q.pop_front());
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    sbi.dc2sb_command     = BUS_NONE;
    sbi.dc2sb_addr        = '0;
    sbi.dc2sb_data        = '0;
    sbi.mem2proc_response = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    q.delete();
  endtask

  initial begin
    bus_command_t  rc;
    logic [31:0]   ra;
    logic [TW-1:0] rr;
    int            mi;
    reset                 = 1'b1;
    sbi.dc2sb_command     = BUS_NONE;
    sbi.dc2sb_addr        = '0;
    sbi.dc2sb_data        = '0;
    sbi.mem2proc_response = '0;
    sbi.mem2proc_data     = '0;
    sbi.mem2proc_tag      = '0;
    do_reset();

    // Reset state on idle cycles.
    repeat (3) step(BUS_NONE, 32'h0, '0, 4'd0);
    chk("rst_empty", 64'(obs_empty), 64'd1);
    chk("rst_full",  64'(obs_full),  64'd0);

    // Enqueue two lines and drain them in order.
    step(BUS_STORE, 32'h100, 64'hD0D0_0000_0000_00D0, 4'd1);
    step(BUS_STORE, 32'h200, 64'hD1D1_0000_0000_00D1, 4'd1);
    step(BUS_NONE, 32'h0, '0, 4'd1);
    chk("ed_cmd0",  64'(obs_cmd), 64'(BUS_STORE));
    chk("ed_addr0", 64'(obs_addr), 64'h100);
    chk("ed_data0", obs_data, 64'hD0D0_0000_0000_00D0);
    step(BUS_NONE, 32'h0, '0, 4'd1);
    chk("ed_addr1", 64'(obs_addr), 64'h200);
    chk("ed_data1", obs_data, 64'hD1D1_0000_0000_00D1);
    step(BUS_NONE, 32'h0, '0, 4'd1);
    chk("ed_empty", 64'(obs_empty), 64'd1);

    // Two stores to one line collapse into one drain carrying the later data.
    step(BUS_STORE, 32'h108, 64'hAAAA_AAAA_AAAA_AAAA, 4'd0);
    step(BUS_STORE, 32'h10C, 64'hBBBB_BBBB_BBBB_BBBB, 4'd0);
    step(BUS_NONE, 32'h0, '0, 4'd1);
    chk("co_addr", 64'(obs_addr), 64'h108);
    chk("co_data", obs_data, 64'hBBBB_BBBB_BBBB_BBBB);
    step(BUS_NONE, 32'h0, '0, 4'd0);
    chk("co_empty", 64'(obs_empty), 64'd1);

    // A load to a buffered line is held until that line drains.
    step(BUS_STORE, 32'h300, 64'hC0FFEE, 4'd0);
    step(BUS_LOAD, 32'h304, '0, 4'd0);
    step(BUS_LOAD, 32'h304, '0, 4'd0);
    chk("hz_stall", 64'(obs_stall), 64'd1);
    step(BUS_LOAD, 32'h304, '0, 4'd3);
    chk("hz_resp0", 64'(obs_resp), 64'd0);
    step(BUS_LOAD, 32'h304, '0, 4'd3);
    chk("hz_cmd",   64'(obs_cmd), 64'(BUS_LOAD));
    chk("hz_resp",  64'(obs_resp), 64'd3);
    chk("hz_nostall", 64'(obs_stall), 64'd0);

    // Fill the buffer, coalesce into it while full, then free one entry.
    for (int i = 0; i < SB_DEPTH; i++)
      step(BUS_STORE, 32'h400 + 32'(i * 8), 64'(32'hF000 + i), 4'd0);
    step(BUS_STORE, 32'h408, 64'h5555, 4'd0);
    chk("fu_full", 64'(obs_full), 64'd1);
    step(BUS_NONE, 32'h0, '0, 4'd2);
    chk("fu_full_pop", 64'(obs_full), 64'd1);
    step(BUS_NONE, 32'h0, '0, 4'd0);
    chk("fu_not_full", 64'(obs_full), 64'd0);
    step(BUS_NONE, 32'h0, '0, 4'd1);
    chk("fu_coal_data", obs_data, 64'h5555);
    repeat (3) step(BUS_NONE, 32'h0, '0, 4'd1);

    // A non-matching load wins over pending drains.
    step(BUS_STORE, 32'h600, 64'h66, 4'd0);
    step(BUS_STORE, 32'h608, 64'h67, 4'd0);
    step(BUS_LOAD, 32'h500, '0, 4'd5);
    chk("lp_cmd",  64'(obs_cmd), 64'(BUS_LOAD));
    chk("lp_addr", 64'(obs_addr), 64'h500);
    chk("lp_resp", 64'(obs_resp), 64'd5);
    step(BUS_NONE, 32'h0, '0, 4'd0);
    chk("lp_head", 64'(obs_addr), 64'h600);

    // Reset in the middle of a drain discards everything buffered.
    do_reset();
    step(BUS_NONE, 32'h0, '0, 4'd1);
    chk("rd_empty", 64'(obs_empty), 64'd1);
    chk("rd_cmd",   64'(obs_cmd), 64'(BUS_NONE));

    // Randomized traffic over a small set of lines to provoke hits.
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 2))
        0:       rc = BUS_NONE;
        1:       rc = BUS_LOAD;
        default: rc = BUS_STORE;
      endcase
      ra = 32'h1000 + 32'($urandom_range(0, 7) * 8) + 32'($urandom_range(0, 7));
      rr = ($urandom_range(0, 1) == 0) ? '0 : TW'($urandom_range(1, 15));
      mi = -1;
      foreach (q[i]) if (q[i].line == ra[31:3]) mi = i;
      if (rc == BUS_STORE && mi < 0 && q.size() == SB_DEPTH) rc = BUS_NONE;
      step(rc, ra, {$urandom, $urandom}, rr);
    end
    repeat (SB_DEPTH + 1) step(BUS_NONE, 32'h0, '0, 4'd1);
    chk("final_empty", 64'(obs_empty), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
